spi_slave_mode: RTL and testbench
=================================

# spi_slave_mode

Parametrised SPI slave for the peripheral register interface. It oversamples the SPI pins in the `clk` domain and supports all four CPOL/CPHA modes and a configurable data width. Each frame starts with a read/write command bit. Received words and words to transmit pass over valid/ready handshakes, so the block sits between an external SPI master and the on-chip register/RAM controller.

## Interface
- `DATA_W`, default 8: payload bits per frame, excluding the command bit; legal range 4–32.
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `SYNC_STAGES`, default 2: flops in each pin synchroniser; minimum 2.
- `clk` input 1: system clock; must run at ≥4× the SCLK frequency.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sclk` input 1: SPI clock, asynchronous.
- `ss_n` input 1: slave select, active-low, asynchronous.
- `mosi` input 1: serial data in.
- `miso` output 1: serial data out, MSB first.
- `miso_oe` output 1: high while selected in a read frame; the pad tristates otherwise.
- `rx_data` output DATA_W: last received write word.
- `rx_valid` output 1: `rx_data` holds an unconsumed word.
- `rx_ready` input 1: consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `tx_data` input DATA_W: word to return on the next read frame.
- `tx_valid` input 1: `tx_data` is offered.
- `tx_ready` output 1: the TX holding register is empty; the offer is accepted when `tx_valid && tx_ready`.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `overrun` output 1: present only with `SPI_SLAVE_OVERRUN_EN`; sticky RX overrun flag.

## Operation
- `sclk`, `ss_n` and `mosi` each pass through `SYNC_STAGES` flops. Edges are detected on the synchronised `sclk`:
  - Leading edge = transition away from the `CPOL` level; trailing edge = transition back to it.
  - Sample edge = leading edge if `CPHA`=0, else trailing edge. Shift edge = the other one.
- States: IDLE, CMD, WRITE, READ, DONE.
  - IDLE → CMD on synchronised `ss_n` falling. The bit counter clears.
  - CMD: the first sample edge captures `mosi` as RW.
    - RW=0 → WRITE.
    - RW=1 → READ. The shift register loads the TX holding register, or all zeros if the holding register is empty (underrun); the holding register is marked empty; `miso_oe` goes to 1.
  - WRITE: each sample edge shifts `mosi` into the LSB (MSB-first). After DATA_W samples: the shift register transfers to `rx_data`, `rx_valid` is set, and the state moves to DONE.
  - READ: each shift edge drives the next bit on `miso`, MSB first. The first data bit is driven on the first shift edge after the command sample. After DATA_W bits have been driven and the last sample edge has passed → DONE.
  - DONE: further SCLK edges are ignored; `miso` holds the last bit. Synchronised `ss_n` rising → IDLE.
- `ss_n` rising in CMD, WRITE or READ aborts the frame and returns to IDLE:
  - a partial write word is discarded and `rx_valid` is unchanged;
  - a partial read still consumes the holding register.
- `miso_oe` = 0 in every state except READ and DONE-after-READ.
- TX holding register loads on `tx_valid && tx_ready`. If the register load and the read-command consume fall in the same cycle, the consume uses the old (empty) contents and the new word is stored.
- `rx_valid` clears on `rx_valid && rx_ready`. If a set and a clear coincide, the set wins and `rx_data` takes the new word.
- Bit counter is $clog2(DATA_W+1) bits wide and saturates at DATA_W.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `busy`=0, `overrun`=0. The state is IDLE and the holding register is empty.
- Reset is asynchronous. Asserting it mid-frame aborts immediately; after release the block waits for a fresh `ss_n` falling edge.
- Pin-to-edge-detect latency is SYNC_STAGES+1 clk cycles.
- `rx_valid` rises 1 clk after the DATA_W-th sample edge is detected.
- `miso` changes 1 clk after the shift edge is detected, i.e. ≤ SYNC_STAGES+2 clk after the SCLK pin edge.
- `tx_ready` falls 1 clk after acceptance and rises 1 clk after the read-command consume.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - The `overrun` port exists.
  - A write frame that completes while `rx_valid`=1 leaves `rx_data` unchanged, drops the new word, and sets `overrun`.
  - `overrun` clears on the next `rx_valid && rx_ready` handshake.
- Undefined:
  - There is no `overrun` port.
  - A completing write always overwrites `rx_data`; `rx_valid` stays 1.

## Structure
- Package `spi_slave_pkg`: state enum (IDLE, CMD, WRITE, READ, DONE) and RW command constants (CMD_WRITE=0, CMD_READ=1).
- Sub-module `spi_sync_edge`: `SYNC_STAGES` synchroniser plus rise/fall pulse outputs, instanced for `sclk` and `ss_n`. `mosi` uses the synchroniser only.

## Test plan
- Mode 0, DATA_W=8: frame RW=0 followed by 0xA5 → `rx_data`=0xA5 and `rx_valid`=1 one clk after the 8th sample; `miso_oe` stays 0.
- Mode 3: load `tx_data`=0x3C, then frame RW=1 → master captures 0x3C MSB-first; `tx_ready` returns to 1 after the command bit.
- Mode 1, read frame with an empty holding register → master receives 0x00, with no hang.
- `ss_n` deasserted after 4 write bits → state IDLE, `rx_valid` stays 0; a following full write of 0x81 is received correctly.
- Two write frames 0x11 then 0x22 with `rx_ready`=0:
  - with `SPI_SLAVE_OVERRUN_EN` → `rx_data`=0x11 and `overrun`=1, cleared by the handshake;
  - without the macro → `rx_data`=0x22.
- DATA_W=16, `rst_n` pulsed mid-read → all outputs return to reset values; the next read frame returns the newly loaded 0xBEEF.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave: frame state encoding and the command-bit
// values carried in the first bit of every frame.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise and
// fall pulses on the synchronised level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous pin
//   rise, fall : one-clk pulses on synchronised 0->1 / 1->0 transitions
// Edges are suppressed until the chain has refilled with real pin samples after
// reset, so a pin that already sits away from RST_VAL does not look like a
// fresh edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise = vld_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = vld_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_mode.sv
// Oversampled SPI slave, all four CPOL/CPHA modes. Each frame is one command
// bit (0 = write, 1 = read) followed by DATA_W payload bits, MSB first.
// Received words leave on rx_data/rx_valid/rx_ready; words to return enter a
// one-deep holding register through tx_data/tx_valid/tx_ready.
//   clk, rst_n         : system clock (>= 4x SCLK), async active-low reset
//   sclk, ss_n, mosi   : SPI pins, asynchronous to clk
//   miso, miso_oe      : serial data out and its pad output enable
//   rx_data, rx_valid, rx_ready : received write word handshake
//   tx_data, tx_valid, tx_ready : read-return word handshake
//   busy               : a frame is in progress
//   overrun            : sticky RX overrun (only with SPI_SLAVE_OVERRUN_EN)
// Build option: define SPI_SLAVE_OVERRUN_EN to drop words that complete while
// rx_valid is still set and flag it on `overrun`; otherwise new words overwrite.
module spi_slave_mode
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t                 state, state_nxt;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      shift_q, tx_hold, wr_word;
  logic                   tx_full, rd_frame_q, miso_q;
  logic                   rd_consume, wr_done, tx_accept, rx_take;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Pin synchronisers
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .din(ss_n), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi only needs its level; its chain matches sclk so data and edge align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edge classification: leading = away from the idle level
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

  // An ss_n rise in the same cycle as a sample always wins (frame aborted).
  assign rd_consume = (state == CMD) && sample_edge && !ss_rise && (mosi_s == CMD_READ);
  assign wr_done    = (state == WRITE) && sample_edge && !ss_rise && (bit_cnt == CNT_LAST);
  assign wr_word    = {shift_q[DATA_W-2:0], mosi_s};
  assign tx_accept  = tx_valid && !tx_full;
  assign rx_take    = rx_valid && rx_ready;

  // Frame FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ss_fall) state_nxt = CMD;
      CMD:   if (ss_rise) state_nxt = IDLE;
             else if (sample_edge) state_nxt = (mosi_s == CMD_WRITE) ? WRITE : READ;
      WRITE: if (ss_rise) state_nxt = IDLE;
             else if (wr_done) state_nxt = DONE;
      READ:  if (ss_rise) state_nxt = IDLE;
             else if (sample_edge && (bit_cnt == CNT_MAX)) state_nxt = DONE;
      DONE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame FSM: outputs
  always_comb begin
    busy    = (state != IDLE);
    miso_oe = (state == READ) || ((state == DONE) && rd_frame_q);
  end

  assign miso     = miso_q;
  assign tx_ready = !tx_full;

  // Control and externally visible registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rd_frame_q <= 1'b0;
      miso_q     <= 1'b0;
      tx_full    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      if ((state == IDLE) && ss_fall) begin
        bit_cnt    <= '0;
        rd_frame_q <= 1'b0;
      end else if (((state == WRITE) && sample_edge) || ((state == READ) && shift_edge)) begin
        bit_cnt <= sat_inc(bit_cnt);
      end

      if (rd_consume) rd_frame_q <= 1'b1;

      if ((state == READ) && shift_edge && (bit_cnt != CNT_MAX)) miso_q <= shift_q[DATA_W-1];

      // A word offered in the consume cycle is stored; the consume saw empty.
      if (tx_accept)       tx_full <= 1'b1;
      else if (rd_consume) tx_full <= 1'b0;

`ifdef SPI_SLAVE_OVERRUN_EN
      if (wr_done && (!rx_valid || rx_take)) begin
        rx_data  <= wr_word;
        rx_valid <= 1'b1;
      end else if (rx_take) begin
        rx_valid <= 1'b0;
      end
      if (rx_take)                  overrun <= 1'b0;
      else if (wr_done && rx_valid) overrun <= 1'b1;
`else
      if (wr_done) begin
        rx_data  <= wr_word;
        rx_valid <= 1'b1;
      end else if (rx_take) begin
        rx_valid <= 1'b0;
      end
`endif
    end
  end

  // Shift and holding registers (data path, no reset)
  always_ff @(posedge clk) begin
    if (rd_consume)                          shift_q <= tx_full ? tx_hold : '0;
    else if ((state == WRITE) && sample_edge) shift_q <= wr_word;
    else if ((state == READ) && shift_edge)   shift_q <= {shift_q[DATA_W-2:0], 1'b0};

    if (tx_accept) tx_hold <= tx_data;
  end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: three instances (mode 0 / 8 bit, mode 3 / 8 bit,
// mode 1 / 16 bit) driven by a behavioural SPI master, checked against a
// transaction-level model of the RX word slot and TX holding register.
module tb_spi_slave_mode;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sclk_p[3], ss_n_p[3], mosi_p[3], rxr[3], txv[3];
  logic [31:0] txd[3];
  logic        miso_w[3], oe_w[3], rxv_w[3], txr_w[3], busy_w[3];
  logic [31:0] rxd_w[3];
  logic [7:0]  rxd0, rxd1;
  logic [15:0] rxd2;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic        ovr_w[3];
`endif

  assign rxd_w[0] = {24'h0, rxd0};
  assign rxd_w[1] = {24'h0, rxd1};
  assign rxd_w[2] = {16'h0, rxd2};

  spi_slave_mode #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[0]), .ss_n(ss_n_p[0]), .mosi(mosi_p[0]),
    .miso(miso_w[0]), .miso_oe(oe_w[0]), .rx_data(rxd0), .rx_valid(rxv_w[0]),
    .rx_ready(rxr[0]), .tx_data(txd[0][7:0]), .tx_valid(txv[0]), .tx_ready(txr_w[0]),
    .busy(busy_w[0])
`ifdef SPI_SLAVE_OVERRUN_EN
    , .overrun(ovr_w[0])
`endif
  );

  spi_slave_mode #(.DATA_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[1]), .ss_n(ss_n_p[1]), .mosi(mosi_p[1]),
    .miso(miso_w[1]), .miso_oe(oe_w[1]), .rx_data(rxd1), .rx_valid(rxv_w[1]),
    .rx_ready(rxr[1]), .tx_data(txd[1][7:0]), .tx_valid(txv[1]), .tx_ready(txr_w[1]),
    .busy(busy_w[1])
`ifdef SPI_SLAVE_OVERRUN_EN
    , .overrun(ovr_w[1])
`endif
  );

  spi_slave_mode #(.DATA_W(16), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) u_m1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_p[2]), .ss_n(ss_n_p[2]), .mosi(mosi_p[2]),
    .miso(miso_w[2]), .miso_oe(oe_w[2]), .rx_data(rxd2), .rx_valid(rxv_w[2]),
    .rx_ready(rxr[2]), .tx_data(txd[2][15:0]), .tx_valid(txv[2]), .tx_ready(txr_w[2]),
    .busy(busy_w[2])
`ifdef SPI_SLAVE_OVERRUN_EN
    , .overrun(ovr_w[2])
`endif
  );

  int nchecks = 0;
  int nerrors = 0;

  // Reference model state
  logic        m_full[3], m_rxv[3], m_ovr[3];
  logic [31:0] m_hold[3], m_rxd[3];

  time t_samp[3];
  time t_rxv0;
  int  oe_cnt[3];

  always @(posedge rxv_w[0]) t_rxv0 = $time;
  always @(posedge clk) for (int k = 0; k < 3; k++) if (oe_w[k]) oe_cnt[k] = oe_cnt[k] + 1;

  function automatic int w_of(input int d);
    return (d == 2) ? 16 : 8;
  endfunction
  function automatic logic cpol_of(input int d);
    return (d == 1);
  endfunction
  function automatic logic cpha_of(input int d);
    return (d != 0);
  endfunction
  function automatic logic [31:0] mask_of(input int d);
    return (32'h1 << w_of(d)) - 32'h1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_full[k] = 1'b0; m_rxv[k] = 1'b0; m_ovr[k] = 1'b0;
      m_hold[k] = '0;   m_rxd[k] = '0;
    end
  endtask

  task automatic model_write(input int d, input logic [31:0] word);
`ifdef SPI_SLAVE_OVERRUN_EN
    if (m_rxv[d]) m_ovr[d] = 1'b1;
    else begin
      m_rxd[d] = word & mask_of(d);
      m_rxv[d] = 1'b1;
    end
`else
    m_rxd[d] = word & mask_of(d);
    m_rxv[d] = 1'b1;
`endif
  endtask

  task automatic model_read(input int d, output logic [31:0] exp);
    exp = m_full[d] ? m_hold[d] : 32'h0;
    m_full[d] = 1'b0;
  endtask

  // Behavioural SPI master: nbits includes the command bit.
  task automatic spi_frame(input int d, input logic rw, input logic [31:0] wdata,
                           input int nbits, output logic [31:0] rdata);
    int   w;
    logic cpol, cpha, b;
    w = w_of(d); cpol = cpol_of(d); cpha = cpha_of(d);
    rdata = '0;
    ss_n_p[d] = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      b = (i == 0) ? rw : wdata[w - i];
      if (!cpha) begin
        mosi_p[d] = b;
        #HALF;
        sclk_p[d] = ~cpol;
        if (i == nbits - 1) t_samp[d] = $time;
        if (i > 0) rdata = {rdata[30:0], miso_w[d]};
        #HALF;
        sclk_p[d] = cpol;
      end else begin
        sclk_p[d] = ~cpol;
        mosi_p[d] = b;
        #HALF;
        sclk_p[d] = cpol;
        if (i == nbits - 1) t_samp[d] = $time;
        if (i > 0) rdata = {rdata[30:0], miso_w[d]};
        #HALF;
      end
    end
    #HALF;
    ss_n_p[d] = 1'b1;
    #(2 * HALF);
  endtask

  task automatic load_tx(input int d, input logic [31:0] val);
    if (!m_full[d]) begin
      txd[d] = val;
      txv[d] = 1'b1;
      @(posedge clk); #5;
      txv[d] = 1'b0;
      m_full[d] = 1'b1;
      m_hold[d] = val & mask_of(d);
    end
  endtask

  task automatic rx_handshake(input int d);
    rxr[d] = 1'b1;
    @(posedge clk); #5;
    rxr[d] = 1'b0;
    if (m_rxv[d]) begin
      m_rxv[d] = 1'b0;
      m_ovr[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #30;
    rst_n = 1'b1;
    #20;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      nchecks++; if (miso_w[d] !== 1'b0) begin nerrors++; $display("FAIL reset_miso[%0d]: got %b expected 0", d, miso_w[d]); end
      nchecks++; if (oe_w[d] !== 1'b0) begin nerrors++; $display("FAIL reset_miso_oe[%0d]: got %b expected 0", d, oe_w[d]); end
      nchecks++; if (rxd_w[d] !== 32'h0) begin nerrors++; $display("FAIL reset_rx_data[%0d]: got %h expected 0", d, rxd_w[d]); end
      nchecks++; if (rxv_w[d] !== 1'b0) begin nerrors++; $display("FAIL reset_rx_valid[%0d]: got %b expected 0", d, rxv_w[d]); end
      nchecks++; if (txr_w[d] !== 1'b1) begin nerrors++; $display("FAIL reset_tx_ready[%0d]: got %b expected 1", d, txr_w[d]); end
      nchecks++; if (busy_w[d] !== 1'b0) begin nerrors++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy_w[d]); end
`ifdef SPI_SLAVE_OVERRUN_EN
      nchecks++; if (ovr_w[d] !== 1'b0) begin nerrors++; $display("FAIL reset_overrun[%0d]: got %b expected 0", d, ovr_w[d]); end
`endif
    end
  endtask

  task automatic test_mode0_write();
    logic [31:0] rd;
    int          oe0;
    time         lat;
    oe0 = oe_cnt[0];
    t_rxv0 = 0;
    spi_frame(0, 1'b0, 32'hA5, 9, rd);
    model_write(0, 32'hA5);
    lat = t_rxv0 - t_samp[0];
    nchecks++; if (lat !== 25) begin nerrors++; $display("FAIL m0_rx_valid_latency: got %0t expected 25", lat); end
    nchecks++; if (rxd_w[0] !== m_rxd[0]) begin nerrors++; $display("FAIL m0_rx_data: got %h expected %h", rxd_w[0], m_rxd[0]); end
    nchecks++; if (rxv_w[0] !== 1'b1) begin nerrors++; $display("FAIL m0_rx_valid: got %b expected 1", rxv_w[0]); end
    nchecks++; if (oe_cnt[0] !== oe0) begin nerrors++; $display("FAIL m0_write_miso_oe: got %0d oe cycles expected 0", oe_cnt[0] - oe0); end
    rx_handshake(0);
    nchecks++; if (rxv_w[0] !== 1'b0) begin nerrors++; $display("FAIL m0_rx_valid_clear: got %b expected 0", rxv_w[0]); end
  endtask

  task automatic test_mode3_read();
    logic [31:0] rd, exp;
    load_tx(1, 32'h3C);
    nchecks++; if (txr_w[1] !== 1'b0) begin nerrors++; $display("FAIL m3_tx_ready_full: got %b expected 0", txr_w[1]); end
    model_read(1, exp);
    spi_frame(1, 1'b1, 32'h0, 9, rd);
    nchecks++; if (rd !== exp) begin nerrors++; $display("FAIL m3_read_data: got %h expected %h", rd, exp); end
    nchecks++; if (txr_w[1] !== 1'b1) begin nerrors++; $display("FAIL m3_tx_ready_after: got %b expected 1", txr_w[1]); end
    nchecks++; if (oe_w[1] !== 1'b0) begin nerrors++; $display("FAIL m3_miso_oe_idle: got %b expected 0", oe_w[1]); end
  endtask

  task automatic test_mode1_empty_read();
    logic [31:0] rd, exp;
    int          oe0;
    oe0 = oe_cnt[2];
    model_read(2, exp);
    spi_frame(2, 1'b1, 32'h0, 17, rd);
    nchecks++; if (rd !== exp) begin nerrors++; $display("FAIL m1_empty_read: got %h expected %h", rd, exp); end
    nchecks++; if (busy_w[2] !== 1'b0) begin nerrors++; $display("FAIL m1_busy_after: got %b expected 0", busy_w[2]); end
    nchecks++; if (oe_cnt[2] == oe0) begin nerrors++; $display("FAIL m1_read_miso_oe: got 0 oe cycles expected >0"); end
  endtask

  task automatic test_random_ops(input int d, input int n);
    logic [31:0] rd, exp, word;
    int          op;
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        word = $urandom & mask_of(d);
        spi_frame(d, 1'b0, word, w_of(d) + 1, rd);
        model_write(d, word);
        nchecks++; if (rxd_w[d] !== m_rxd[d]) begin nerrors++; $display("FAIL rand_rx_data[%0d]: got %h expected %h", d, rxd_w[d], m_rxd[d]); end
        nchecks++; if (rxv_w[d] !== m_rxv[d]) begin nerrors++; $display("FAIL rand_rx_valid[%0d]: got %b expected %b", d, rxv_w[d], m_rxv[d]); end
        rx_handshake(d);
      end else begin
        if (op == 1) load_tx(d, $urandom);
        model_read(d, exp);
        spi_frame(d, 1'b1, 32'h0, w_of(d) + 1, rd);
        nchecks++; if (rd !== exp) begin nerrors++; $display("FAIL rand_read[%0d]: got %h expected %h", d, rd, exp); end
        nchecks++; if (txr_w[d] !== !m_full[d]) begin nerrors++; $display("FAIL rand_tx_ready[%0d]: got %b expected %b", d, txr_w[d], !m_full[d]); end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    spi_frame(0, 1'b0, 32'hF0, 5, rd);
    nchecks++; if (busy_w[0] !== 1'b0) begin nerrors++; $display("FAIL abort_busy: got %b expected 0", busy_w[0]); end
    nchecks++; if (rxv_w[0] !== m_rxv[0]) begin nerrors++; $display("FAIL abort_rx_valid: got %b expected %b", rxv_w[0], m_rxv[0]); end
    spi_frame(0, 1'b0, 32'h81, 9, rd);
    model_write(0, 32'h81);
    nchecks++; if (rxd_w[0] !== m_rxd[0]) begin nerrors++; $display("FAIL abort_next_rx_data: got %h expected %h", rxd_w[0], m_rxd[0]); end
    nchecks++; if (rxv_w[0] !== 1'b1) begin nerrors++; $display("FAIL abort_next_rx_valid: got %b expected 1", rxv_w[0]); end
    rx_handshake(0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    spi_frame(0, 1'b0, 32'h11, 9, rd);
    model_write(0, 32'h11);
    spi_frame(0, 1'b0, 32'h22, 9, rd);
    model_write(0, 32'h22);
    nchecks++; if (rxd_w[0] !== m_rxd[0]) begin nerrors++; $display("FAIL b2b_rx_data: got %h expected %h", rxd_w[0], m_rxd[0]); end
    nchecks++; if (rxv_w[0] !== 1'b1) begin nerrors++; $display("FAIL b2b_rx_valid: got %b expected 1", rxv_w[0]); end
`ifdef SPI_SLAVE_OVERRUN_EN
    nchecks++; if (ovr_w[0] !== m_ovr[0]) begin nerrors++; $display("FAIL b2b_overrun_set: got %b expected %b", ovr_w[0], m_ovr[0]); end
`endif
    rx_handshake(0);
    nchecks++; if (rxv_w[0] !== 1'b0) begin nerrors++; $display("FAIL b2b_rx_valid_clear: got %b expected 0", rxv_w[0]); end
`ifdef SPI_SLAVE_OVERRUN_EN
    nchecks++; if (ovr_w[0] !== 1'b0) begin nerrors++; $display("FAIL b2b_overrun_clear: got %b expected 0", ovr_w[0]); end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd, exp;
    load_tx(2, 32'h1234);
    fork
      spi_frame(2, 1'b1, 32'h0, 17, rd);
      begin
        #1080;
        nchecks++; if (oe_w[2] !== 1'b1) begin nerrors++; $display("FAIL midread_miso_oe: got %b expected 1", oe_w[2]); end
        rst_n = 1'b0;
        #2;
        nchecks++; if (busy_w[2] !== 1'b0) begin nerrors++; $display("FAIL midread_busy_rst: got %b expected 0", busy_w[2]); end
        nchecks++; if (oe_w[2] !== 1'b0) begin nerrors++; $display("FAIL midread_oe_rst: got %b expected 0", oe_w[2]); end
        nchecks++; if (miso_w[2] !== 1'b0) begin nerrors++; $display("FAIL midread_miso_rst: got %b expected 0", miso_w[2]); end
        nchecks++; if (txr_w[2] !== 1'b1) begin nerrors++; $display("FAIL midread_tx_ready_rst: got %b expected 1", txr_w[2]); end
        nchecks++; if (rxd_w[2] !== 32'h0) begin nerrors++; $display("FAIL midread_rx_data_rst: got %h expected 0", rxd_w[2]); end
        nchecks++; if (rxv_w[2] !== 1'b0) begin nerrors++; $display("FAIL midread_rx_valid_rst: got %b expected 0", rxv_w[2]); end
        #28;
        rst_n = 1'b1;
      end
    join
    model_reset();
    nchecks++; if (busy_w[2] !== 1'b0) begin nerrors++; $display("FAIL midread_busy_after: got %b expected 0", busy_w[2]); end
    load_tx(2, 32'hBEEF);
    model_read(2, exp);
    spi_frame(2, 1'b1, 32'h0, 17, rd);
    nchecks++; if (rd !== exp) begin nerrors++; $display("FAIL midread_next_read: got %h expected %h", rd, exp); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      sclk_p[k] = cpol_of(k);
      ss_n_p[k] = 1'b1;
      mosi_p[k] = 1'b0;
      rxr[k]    = 1'b0;
      txv[k]    = 1'b0;
      txd[k]    = '0;
      oe_cnt[k] = 0;
      t_samp[k] = 0;
    end
    test_reset();
    test_mode0_write();
    test_mode3_read();
    test_mode1_empty_read();
    test_abort();
    test_back_to_back();
    test_random_ops(0, 6);
    test_random_ops(1, 6);
    test_random_ops(2, 4);
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
